// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges the ALU, LSB and Branch result streams onto one
// registered common data bus. Each producer feeds a private FIFO; a
// three-way round-robin arbiter pops at most one entry per cycle and
// broadcasts it as a single tag/data pair.
module cdb_arbiter #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_full,
  input  logic              lsb_valid,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_data,
  output logic              lsb_full,
  input  logic              br_valid,
  input  logic [TAG_W-1:0]  br_tag,
  input  logic [DATA_W-1:0] br_data,
  output logic              br_full,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic [1:0]        cdb_src
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Round-robin successor; rr pointer cycles 0 -> 1 -> 2 -> 0 and never hits 3.
  function automatic logic [1:0] next_src(input logic [1:0] src);
    case (src)
      2'd0:    next_src = 2'd1;
      2'd1:    next_src = 2'd2;
      default: next_src = 2'd0;
    endcase
  endfunction

  // Source-indexed views of the producer ports (0 = ALU, 1 = LSB, 2 = Branch).
  logic [2:0]        in_valid_s;
  logic [TAG_W-1:0]  in_tag_s  [3];
  logic [DATA_W-1:0] in_data_s [3];

  logic [PTR_W-1:0]  head_r  [3];
  logic [PTR_W-1:0]  tail_r  [3];
  logic [CNT_W-1:0]  count_r [3];
  logic [TAG_W-1:0]  tag_mem_r  [3][DEPTH];
  logic [DATA_W-1:0] data_mem_r [3][DEPTH];
  logic [1:0]        rr_ptr_r;

  logic [2:0]        full_s;
  logic [2:0]        cand_s;
  logic [2:0]        push_s;
  logic [2:0]        pop_s;
  logic              grant_valid_s;
  logic [1:0]        grant_s;
  logic [1:0]        scan1_s;
  logic [1:0]        scan2_s;
  logic [TAG_W-1:0]  grant_tag_s;
  logic [DATA_W-1:0] grant_data_s;

  assign in_valid_s   = {br_valid, lsb_valid, alu_valid};
  assign in_tag_s[0]  = alu_tag;
  assign in_tag_s[1]  = lsb_tag;
  assign in_tag_s[2]  = br_tag;
  assign in_data_s[0] = alu_data;
  assign in_data_s[1] = lsb_data;
  assign in_data_s[2] = br_data;

  assign alu_full = full_s[0];
  assign lsb_full = full_s[1];
  assign br_full  = full_s[2];

  // Full and non-empty flags come from registered counts only, so a pop in
  // the same cycle never relieves a full FIFO and fresh pushes are never
  // candidates before they are stored.
  always_comb begin
    full_s = 3'b000;
    cand_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      full_s[i] = (count_r[i] == DEPTH_CNT) | ~rdy;
      cand_s[i] = (count_r[i] != {CNT_W{1'b0}});
    end
  end

  // Round-robin grant: first non-empty source scanning from rr_ptr.
  always_comb begin
    scan1_s       = next_src(rr_ptr_r);
    scan2_s       = next_src(scan1_s);
    grant_valid_s = 1'b1;
    grant_s       = rr_ptr_r;
    if (cand_s[rr_ptr_r]) begin
      grant_s = rr_ptr_r;
    end else if (cand_s[scan1_s]) begin
      grant_s = scan1_s;
    end else if (cand_s[scan2_s]) begin
      grant_s = scan2_s;
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 2'd0;
    end
  end

  // Head entry of the granted FIFO, plus per-source push/pop strobes.
  always_comb begin
    grant_tag_s  = tag_mem_r[grant_s][head_r[grant_s]];
    grant_data_s = data_mem_r[grant_s][head_r[grant_s]];
    push_s       = 3'b000;
    pop_s        = 3'b000;
    for (int i = 0; i < 3; i++) begin
      push_s[i] = rdy & ~clear & in_valid_s[i] & ~full_s[i];
      pop_s[i]  = rdy & ~clear & grant_valid_s & (grant_s == 2'(i));
    end
  end

  // Entry storage; contents are only meaningful where the count says so.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push_s[i]) begin
        tag_mem_r[i][tail_r[i]]  <= in_tag_s[i];
        data_mem_r[i][tail_r[i]] <= in_data_s[i];
      end
    end
  end

  // FIFO pointers/counts, arbiter pointer and the registered CDB outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        head_r[i]  <= {PTR_W{1'b0}};
        tail_r[i]  <= {PTR_W{1'b0}};
        count_r[i] <= {CNT_W{1'b0}};
      end
      rr_ptr_r  <= 2'd0;
      cdb_valid <= 1'b0;
      cdb_tag   <= {TAG_W{1'b0}};
      cdb_data  <= {DATA_W{1'b0}};
      cdb_src   <= 2'd0;
    end else if (clear) begin
      for (int i = 0; i < 3; i++) begin
        head_r[i]  <= {PTR_W{1'b0}};
        tail_r[i]  <= {PTR_W{1'b0}};
        count_r[i] <= {CNT_W{1'b0}};
      end
      rr_ptr_r  <= 2'd0;
      cdb_valid <= 1'b0;
      cdb_tag   <= {TAG_W{1'b0}};
      cdb_data  <= {DATA_W{1'b0}};
      cdb_src   <= 2'd0;
    end else if (rdy) begin
      for (int i = 0; i < 3; i++) begin
        if (push_s[i]) begin
          tail_r[i] <= tail_r[i] + PTR_W'(1);
        end
        if (pop_s[i]) begin
          head_r[i] <= head_r[i] + PTR_W'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
          2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
      cdb_valid <= grant_valid_s;
      if (grant_valid_s) begin
        cdb_tag  <= grant_tag_s;
        cdb_data <= grant_data_s;
        cdb_src  <= grant_s;
        rr_ptr_r <= next_src(grant_s);
      end else begin
        cdb_tag  <= {TAG_W{1'b0}};
        cdb_data <= {DATA_W{1'b0}};
        cdb_src  <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (TAG_W=4, DATA_W=32, DEPTH=2).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        alu_valid;
  logic [3:0]  alu_tag;
  logic [31:0] alu_data;
  logic        alu_full;
  logic        lsb_valid;
  logic [3:0]  lsb_tag;
  logic [31:0] lsb_data;
  logic        lsb_full;
  logic        br_valid;
  logic [3:0]  br_tag;
  logic [31:0] br_data;
  logic        br_full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;

  int checks;
  int failures;

  cdb_arbiter #(.TAG_W(4), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_data(alu_data), .alu_full(alu_full),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_data(lsb_data), .lsb_full(lsb_full),
    .br_valid(br_valid), .br_tag(br_tag), .br_data(br_data), .br_full(br_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data word derived from the tag so a tag/data mix-up is visible.
  function automatic logic [31:0] mkd(input logic [3:0] t);
    mkd = {4'h0, t, t, t, t, 8'h3C, t};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_cdb(input string n, input logic v, input logic [3:0] t,
                            input logic [31:0] d, input logic [1:0] s);
    check_eq({n, ".valid"}, {31'd0, cdb_valid}, {31'd0, v});
    check_eq({n, ".tag"},   {28'd0, cdb_tag},   {28'd0, t});
    check_eq({n, ".data"},  cdb_data,           d);
    check_eq({n, ".src"},   {30'd0, cdb_src},   {30'd0, s});
  endtask

  task automatic expect_idle(input string n);
    expect_cdb(n, 1'b0, 4'd0, 32'd0, 2'd0);
  endtask

  task automatic expect_full(input string n, input logic [2:0] f);
    check_eq(n, {29'd0, br_full, lsb_full, alu_full}, {29'd0, f});
  endtask

  task automatic drive(input logic av, input logic [3:0] at, input logic lv,
                       input logic [3:0] lt, input logic bv, input logic [3:0] bt);
    alu_valid = av; alu_tag = at; alu_data = mkd(at);
    lsb_valid = lv; lsb_tag = lt; lsb_data = mkd(lt);
    br_valid  = bv; br_tag  = bt; br_data  = mkd(bt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    expect_idle("reset");
    expect_full("reset.full", 3'b000);
    rst = 1'b0;

    // Single push: visible one edge after the push edge, then a one-cycle pulse.
    drive(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0);
    alu_data = 32'h1234;
    step(); expect_idle("single.e0");
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("single.e1", 1'b1, 4'd5, 32'h1234, 2'd0);
    step(); expect_idle("single.e2");

    // Three-way contention from rr_ptr=0.
    do_clear();
    drive(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3);
    step(); expect_idle("three.e0");
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("three.e1", 1'b1, 4'd1, mkd(4'd1), 2'd0);
    step(); expect_cdb("three.e2", 1'b1, 4'd2, mkd(4'd2), 2'd1);
    step(); expect_cdb("three.e3", 1'b1, 4'd3, mkd(4'd3), 2'd2);
    step(); expect_idle("three.e4");

    // Fairness: rr_ptr back at 0, ALU streaming, LSB tag 7 granted 2nd.
    drive(1'b1, 4'd8, 1'b1, 4'd7, 1'b0, 4'd0);
    step(); expect_idle("fair.e0");
    drive(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("fair.e1", 1'b1, 4'd8, mkd(4'd8), 2'd0);
    drive(1'b1, 4'd10, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("fair.e2", 1'b1, 4'd7, mkd(4'd7), 2'd1);
    expect_full("fair.full", 3'b001);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("fair.e3", 1'b1, 4'd9, mkd(4'd9), 2'd0);
    step(); expect_cdb("fair.e4", 1'b1, 4'd10, mkd(4'd10), 2'd0);
    step(); expect_idle("fair.e5");

    // Backpressure: ALU fills, held push accepted only after the FIFO drains.
    do_clear();
    drive(1'b1, 4'd10, 1'b1, 4'd1, 1'b1, 4'd5);
    step(); expect_idle("bp.e0");
    drive(1'b1, 4'd11, 1'b1, 4'd2, 1'b1, 4'd6);
    step(); expect_cdb("bp.e1", 1'b1, 4'd10, mkd(4'd10), 2'd0);
    expect_full("bp.e1.full", 3'b110);
    drive(1'b1, 4'd12, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("bp.e2", 1'b1, 4'd1, mkd(4'd1), 2'd1);
    expect_full("bp.e2.full", 3'b101);
    drive(1'b1, 4'd13, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("bp.e3", 1'b1, 4'd5, mkd(4'd5), 2'd2);
    expect_full("bp.e3.full", 3'b001);
    step(); expect_cdb("bp.e4", 1'b1, 4'd11, mkd(4'd11), 2'd0);
    expect_full("bp.e4.full", 3'b000);
    step(); expect_cdb("bp.e5", 1'b1, 4'd2, mkd(4'd2), 2'd1);
    expect_full("bp.e5.full", 3'b001);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("bp.e6", 1'b1, 4'd6, mkd(4'd6), 2'd2);
    step(); expect_cdb("bp.e7", 1'b1, 4'd12, mkd(4'd12), 2'd0);
    step(); expect_cdb("bp.e8", 1'b1, 4'd13, mkd(4'd13), 2'd0);
    step(); expect_idle("bp.e9");

    // Pointer wrap: twelve ALU entries back-to-back keep their order.
    do_clear();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 4'(i), 1'b0, 4'd0, 1'b0, 4'd0);
      step();
      if (i == 0) begin
        expect_idle("wrap.first");
      end else begin
        expect_cdb("wrap", 1'b1, 4'(i - 1), mkd(4'(i - 1)), 2'd0);
      end
    end
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("wrap.last", 1'b1, 4'd11, mkd(4'd11), 2'd0);
    step(); expect_idle("wrap.end");

    // Stall: rdy low freezes the CDB and forces all full flags.
    do_clear();
    drive(1'b1, 4'd3, 1'b1, 4'd4, 1'b0, 4'd0);
    step(); expect_idle("stall.e0");
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("stall.e1", 1'b1, 4'd3, mkd(4'd3), 2'd0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_cdb("stall.hold", 1'b1, 4'd3, mkd(4'd3), 2'd0);
      expect_full("stall.full", 3'b111);
    end
    rdy = 1'b1;
    step(); expect_cdb("stall.resume", 1'b1, 4'd4, mkd(4'd4), 2'd1);
    step(); expect_idle("stall.end");

    // Flush with rr_ptr=2: queued entries and same-cycle pushes vanish,
    // and rr_ptr returns to 0 (LSB wins over Branch afterwards).
    drive(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3);
    step(); expect_idle("flush.e0");
    clear = 1'b1;
    drive(1'b1, 4'd9, 1'b1, 4'd9, 1'b1, 4'd9);
    step(); expect_idle("flush.e1");
    expect_full("flush.full", 3'b000);
    clear = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_idle("flush.e2");
    step(); expect_idle("flush.e3");
    drive(1'b0, 4'd0, 1'b1, 4'd6, 1'b1, 4'd7);
    step(); expect_idle("flush.e4");
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("flush.e5", 1'b1, 4'd6, mkd(4'd6), 2'd1);
    step(); expect_cdb("flush.e6", 1'b1, 4'd7, mkd(4'd7), 2'd2);
    step(); expect_idle("flush.e7");

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    drive(1'b1, 4'd1, 1'b1, 4'd2, 1'b0, 4'd0);
    step(); expect_idle("arst.e0");
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(); expect_cdb("arst.e1", 1'b1, 4'd1, mkd(4'd1), 2'd0);
    #2 rst = 1'b1;
    #1 expect_idle("arst.async");
    rst = 1'b0;
    step(); expect_idle("arst.e2");
    step(); expect_idle("arst.e3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
